lcd_pixel_streamer: RTL
=======================

Name: lcd_pixel_streamer

Overview:
- Pixel-pull master and ILI9341 4-wire SPI transmitter. It is the requesting end of the framebufferClk / pixel_color interface used by all screen renderers (home, breakout, gif).
- After power-up it hardware-resets the panel, sends a fixed init command list, sets the full-screen window, then streams LCD_W*LCD_H RGB565 pixels per frame, forever.
- For each pixel it latches pixel_color from the selected renderer and issues one framebufferClk pulse so the renderer advances to the next pixel.

Parameters:
- CLK_DIV, 2: clk cycles per SPI sclk half-period. Min 1. One bit = 2*CLK_DIV cycles.
- LCD_W, 240: physical panel width (renderer x count).
- LCD_H, 320: physical panel height (renderer y count).
- RST_CYC, 100000: cycles lcd_rst_n is held low, and cycles waited after it is released.
- DELAY_CYC, 600000: idle cycles after the SWRESET byte and after the SLPOUT byte.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: synchronous active-low reset.
- pixel_color, input, 16: RGB565 from the active renderer. Valid from 2 cycles after any framebufferClk pulse.
- framebufferClk, output, 1: pixel-advance strobe to the renderer. One clk cycle high per pixel.
- frame_start, output, 1: 1-cycle pulse when pixel 0 of each frame is latched.
- lcd_rst_n, output, 1: panel hardware reset.
- lcd_cs_n, output, 1: SPI chip select.
- lcd_dc, output, 1: 0 = command byte, 1 = data byte.
- lcd_sclk, output, 1: SPI clock, mode 0, idles low.
- lcd_mosi, output, 1: SPI data, MSB first.

Behaviour:
- Reset (reset_n sampled low on a clk edge): lcd_rst_n=0, lcd_cs_n=1, lcd_dc=0, lcd_sclk=0, lcd_mosi=0, framebufferClk=0, frame_start=0. Go to HWRST and clear all counters.
- Reset mid-transfer aborts immediately; no partial byte completes.
- HWRST: hold lcd_rst_n=0 for RST_CYC cycles. Then set lcd_rst_n=1 and wait RST_CYC cycles. Then go to INIT.
- lcd_cs_n goes 0 on entry to INIT and stays 0 until the next reset.
- SPI byte engine:
  - Load byte and set dc; drive mosi = bit7.
  - sclk rises CLK_DIV cycles later and falls CLK_DIV cycles after that.
  - mosi updates on each sclk fall.
  - 8 bits = 16*CLK_DIV cycles. Bytes are sent back-to-back with no gap cycles.
  - lcd_dc changes only at byte boundaries, when sclk is low.
- INIT sends this list (C = command, D = data):
  - C 0x01, then DELAY_CYC idle (sclk low).
  - C 0x11, then DELAY_CYC idle.
  - C 0x3A, D 0x55.
  - C 0x36, D 0x48.
  - C 0x29.
- WINDOW, sent before every frame:
  - C 0x2A, D 0x00, D 0x00, D (LCD_W-1)>>8, D (LCD_W-1)&0xFF.
  - C 0x2B, D 0x00, D 0x00, D (LCD_H-1)>>8, D (LCD_H-1)&0xFF.
  - C 0x2C.
- PIXEL state (dc=1), pixel index p = 0 .. LCD_W*LCD_H-1:
  - Cycle P (pixel start): shift register <= pixel_color.
  - Cycle P+1: framebufferClk=1. Cycle P+2: framebufferClk=0.
  - 16 bits are shifted out, high byte first, in 32*CLK_DIV cycles.
  - The next pixel start follows immediately.
  - The renderer advances on the rising edge of framebufferClk, so pixel_color is stable well before the next latch.
- frame_start=1 exactly on cycle P of p=0.
- The last pixel (p = LCD_W*LCD_H-1) is also pulsed, so the renderer wraps to (0,0).
- After the last pixel's final bit, return to WINDOW. Exactly LCD_W*LCD_H pulses are issued per frame.
- The pixel counter has ceil(log2(LCD_W*LCD_H)) bits and wraps only via the frame-end compare.
- No backpressure; framebufferClk is never issued outside the PIXEL state.
- Renderer alignment holds because both blocks leave reset together.

Test Plan:
1. Reset and power-up timing (CLK_DIV=1, RST_CYC=4, DELAY_CYC=3): hold reset_n=0 for 5 cycles -> all outputs at reset values. Release -> lcd_rst_n low for 4 cycles, then high; cs_n falls 4 cycles after that.
2. Init byte stream: SPI monitor decodes 0x01(C), 0x11(C), 0x3A(C), 0x55(D), 0x36(C), 0x48(D), 0x29(C). Exactly 3 idle sclk-low cycles follow each of 0x01 and 0x11. mosi is stable on every sclk rise.
3. Window bytes (LCD_W=4, LCD_H=2): monitor decodes 2A,00,00,00,03,2B,00,00,00,01,2C with DC pattern C,D,D,D,D,C,D,D,D,D,C.
4. Pixel stream (LCD_W=4, LCD_H=2): model renderer returns 0xA500+index. Required response:
   - Data bytes A5 00, A5 01, …, A5 07.
   - 8 framebufferClk pulses, each 1 cycle wide, spaced 32 cycles (CLK_DIV=1).
   - frame_start pulses once, then the window bytes repeat.
5. Second frame: pixel 0 data is again 0xA500. frame_start spacing equals window bytes + 8 pixels (11*16 + 8*32 = 432 cycles at CLK_DIV=1).
6. Reset mid-pixel, asserted at bit 5 of pixel 3: next cycle cs_n=1, sclk=0, framebufferClk=0. After release the full HWRST/INIT sequence repeats from the start.

Source files
------------

// File: rtl/lcd_pixel_streamer.sv
// ILI9341 4-wire SPI streamer: panel reset, init list, full-screen window, then
// pulls one RGB565 pixel per framebufferClk pulse from the renderer, frame after frame.
module lcd_pixel_streamer #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned LCD_W     = 240,
    parameter int unsigned LCD_H     = 320,
    parameter int unsigned RST_CYC   = 100000,
    parameter int unsigned DELAY_CYC = 600000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] pixel_color,
    output logic        framebufferClk,
    output logic        frame_start,
    output logic        lcd_rst_n,
    output logic        lcd_cs_n,
    output logic        lcd_dc,
    output logic        lcd_sclk,
    output logic        lcd_mosi
);
    localparam int unsigned NPIX    = LCD_W * LCD_H;
    localparam int unsigned PIX_W   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int unsigned CNT_MAX = (RST_CYC > DELAY_CYC) ? RST_CYC : DELAY_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SEQ_W   = 5;
    localparam logic [15:0] W_MAX   = 16'(LCD_W - 1);
    localparam logic [15:0] H_MAX   = 16'(LCD_H - 1);

    typedef enum logic [2:0] {
        ST_HWRST,
        ST_INIT,
        ST_WAIT,
        ST_WINDOW,
        ST_PIXEL
    } state_t;

    // Command sequence: entries 0..6 are the init list, 7..17 the window preamble.
    function automatic logic [8:0] seq_entry(input logic [SEQ_W-1:0] idx);
        logic [8:0] e;
        case (idx)
            5'd0:    e = {1'b0, 8'h01};
            5'd1:    e = {1'b0, 8'h11};
            5'd2:    e = {1'b0, 8'h3A};
            5'd3:    e = {1'b1, 8'h55};
            5'd4:    e = {1'b0, 8'h36};
            5'd5:    e = {1'b1, 8'h48};
            5'd6:    e = {1'b0, 8'h29};
            5'd7:    e = {1'b0, 8'h2A};
            5'd8:    e = {1'b1, 8'h00};
            5'd9:    e = {1'b1, 8'h00};
            5'd10:   e = {1'b1, W_MAX[15:8]};
            5'd11:   e = {1'b1, W_MAX[7:0]};
            5'd12:   e = {1'b0, 8'h2B};
            5'd13:   e = {1'b1, 8'h00};
            5'd14:   e = {1'b1, 8'h00};
            5'd15:   e = {1'b1, H_MAX[15:8]};
            5'd16:   e = {1'b1, H_MAX[7:0]};
            5'd17:   e = {1'b0, 8'h2C};
            default: e = '0;
        endcase
        return e;
    endfunction

    state_t             state_q, state_d;
    logic               rst_phase_q, rst_phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [3:0]         bit_q, bit_d;
    logic [15:0]        shreg_q, shreg_d;
    logic               pix_ld_q, pix_ld_d;
    logic               fb_q, fb_d;
    logic               fs_q, fs_d;
    logic               rst_n_q, rst_n_d;
    logic               cs_n_q, cs_n_d;
    logic               dc_q, dc_d;
    logic               sclk_q, sclk_d;

    logic               load_seq;
    logic               load_pix;
    logic [8:0]         seq_ent;
    logic [3:0]         last_bit;

    always_comb begin
        state_d     = state_q;
        rst_phase_d = rst_phase_q;
        cnt_d       = cnt_q;
        seq_d       = seq_q;
        pix_d       = pix_q;
        div_d       = div_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        pix_ld_d    = 1'b0;
        fb_d        = pix_ld_q;
        fs_d        = 1'b0;
        rst_n_d     = rst_n_q;
        cs_n_d      = cs_n_q;
        dc_d        = dc_q;
        sclk_d      = sclk_q;
        load_seq    = 1'b0;
        load_pix    = 1'b0;
        seq_ent     = '0;
        last_bit    = (state_q == ST_PIXEL) ? 4'd15 : 4'd7;

        case (state_q)
            ST_HWRST: begin
                cnt_d = CNT_W'(cnt_q + 1'b1);
                if (cnt_q == CNT_W'(RST_CYC - 1)) begin
                    cnt_d = '0;
                    if (!rst_phase_q) begin
                        rst_phase_d = 1'b1;
                        rst_n_d     = 1'b1;
                    end else begin
                        cs_n_d   = 1'b0;
                        state_d  = ST_INIT;
                        seq_d    = '0;
                        load_seq = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = CNT_W'(cnt_q + 1'b1);
                if (cnt_q == CNT_W'(DELAY_CYC - 1)) begin
                    cnt_d    = '0;
                    state_d  = ST_INIT;
                    seq_d    = SEQ_W'(seq_q + 1'b1);
                    load_seq = 1'b1;
                end
            end
            default: begin
                // Bit engine: sclk toggles every CLK_DIV cycles, mosi shifts on the fall.
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == last_bit) begin
                            bit_d = '0;
                            case (state_q)
                                ST_INIT: begin
                                    if (seq_q < SEQ_W'(2)) begin
                                        state_d = ST_WAIT;
                                        cnt_d   = '0;
                                    end else begin
                                        if (seq_q == SEQ_W'(6)) state_d = ST_WINDOW;
                                        seq_d    = SEQ_W'(seq_q + 1'b1);
                                        load_seq = 1'b1;
                                    end
                                end
                                ST_WINDOW: begin
                                    if (seq_q == SEQ_W'(17)) begin
                                        state_d  = ST_PIXEL;
                                        pix_d    = '0;
                                        load_pix = 1'b1;
                                    end else begin
                                        seq_d    = SEQ_W'(seq_q + 1'b1);
                                        load_seq = 1'b1;
                                    end
                                end
                                ST_PIXEL: begin
                                    if (pix_q == PIX_W'(NPIX - 1)) begin
                                        state_d  = ST_WINDOW;
                                        pix_d    = '0;
                                        seq_d    = SEQ_W'(7);
                                        load_seq = 1'b1;
                                    end else begin
                                        pix_d    = PIX_W'(pix_q + 1'b1);
                                        load_pix = 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end else begin
                            bit_d   = 4'(bit_q + 1'b1);
                            shreg_d = {shreg_q[14:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = DIV_W'(div_q + 1'b1);
                end
            end
        endcase

        if (load_seq) begin
            seq_ent = seq_entry(seq_d);
            dc_d    = seq_ent[8];
            shreg_d = {seq_ent[7:0], 8'h00};
        end
        if (load_pix) begin
            dc_d     = 1'b1;
            shreg_d  = pixel_color;
            pix_ld_d = 1'b1;
            fs_d     = (pix_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_HWRST;
            rst_phase_q <= 1'b0;
            cnt_q       <= '0;
            seq_q       <= '0;
            pix_q       <= '0;
            div_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            pix_ld_q    <= 1'b0;
            fb_q        <= 1'b0;
            fs_q        <= 1'b0;
            rst_n_q     <= 1'b0;
            cs_n_q      <= 1'b1;
            dc_q        <= 1'b0;
            sclk_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_phase_q <= rst_phase_d;
            cnt_q       <= cnt_d;
            seq_q       <= seq_d;
            pix_q       <= pix_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            pix_ld_q    <= pix_ld_d;
            fb_q        <= fb_d;
            fs_q        <= fs_d;
            rst_n_q     <= rst_n_d;
            cs_n_q      <= cs_n_d;
            dc_q        <= dc_d;
            sclk_q      <= sclk_d;
        end
    end

    assign framebufferClk = fb_q;
    assign frame_start    = fs_q;
    assign lcd_rst_n      = rst_n_q;
    assign lcd_cs_n       = cs_n_q;
    assign lcd_dc         = dc_q;
    assign lcd_sclk       = sclk_q;
    assign lcd_mosi       = shreg_q[15];

endmodule
